// File: rtl/aes_pkg.sv
// Shared constants, state encoding and round helpers for the AES-256 core.
// Byte i of a 128-bit state sits at bits [8i+7:8i]; column c holds bytes 4c..4c+3.
package aes_pkg;

   localparam int NR = 14;
   localparam int NK = 8;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

   // Entry 0 is the first round constant; the top entry pads the index range.
   localparam logic [7:0][7:0] RCON = {
      8'h00, 8'h40, 8'h20, 8'h10,
      8'h08, 8'h04, 8'h02, 8'h01
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {b3, b2, b1, b0};
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
// Purely combinational; zero maps to zero before the affine constant.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p, aa, bb;
      p  = '0;
      aa = x;
      bb = z;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   logic [7:0] inv;

   // Square-and-multiply up to x^127, then one final square gives x^254.
   always_comb begin
      inv = a;
      for (int i = 0; i < 6; i++) begin
         inv = gf_mul(gf_mul(inv, inv), a);
      end
      inv = gf_mul(inv, inv);
      y = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
   end

endmodule

// File: rtl/aes256_encrypt_core.sv
// Iterative AES-256 encryptor, one round per clock, key schedule on the fly.
// Optional macro AES256_BUSY_EN adds a busy output high while running.
module aes256_encrypt_core
   import aes_pkg::*;
(
   input  logic         Clk,
   input  logic         Rst,
   input  logic         En,
   input  logic [255:0] cipher_key,
   input  logic [127:0] data_in,
   output logic [127:0] data_out,
   output logic         done
`ifdef AES256_BUSY_EN
   ,
   output logic         busy
`endif
);

   state_t       fsm;
   logic [3:0]   rnd;
   logic [127:0] st;
   logic [255:0] key_win;

   logic [127:0] sub_out;
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [127:0] round_out;
   logic [31:0]  w_prev;
   logic [31:0]  sw_in;
   logic [31:0]  sw_out;
   logic [31:0]  t_word;
   logic [127:0] new_words;
   logic         odd;

   for (genvar g = 0; g < 16; g++) begin : g_sub
      aes_sbox u_sbox (.a(st[8*g +: 8]), .y(sub_out[8*g +: 8]));
   end

   for (genvar g = 0; g < 4; g++) begin : g_sw
      aes_sbox u_sbox (.a(sw_in[8*g +: 8]), .y(sw_out[8*g +: 8]));
   end

   // One cipher round; the final round skips MixColumns.
   always_comb begin
      shifted = shift_rows(sub_out);
      mixed   = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
      end
      round_out = ((rnd == 4'(NR)) ? shifted : mixed) ^ key_win[255:128];
   end

   // Next four schedule words; odd rounds produce a word index i with i mod 8 == 0.
   always_comb begin
      w_prev = key_win[255:224];
      odd    = rnd[0];
      sw_in  = odd ? {w_prev[7:0], w_prev[31:8]} : w_prev;
      t_word = sw_out ^ (odd ? {24'd0, RCON[rnd[3:1]]} : 32'd0);
      new_words[31:0]   = key_win[31:0]   ^ t_word;
      new_words[63:32]  = key_win[63:32]  ^ new_words[31:0];
      new_words[95:64]  = key_win[95:64]  ^ new_words[63:32];
      new_words[127:96] = key_win[127:96] ^ new_words[95:64];
   end

   // Control FSM, data state, key window and outputs.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         fsm      <= S_IDLE;
         rnd      <= '0;
         st       <= '0;
         key_win  <= '0;
         data_out <= '0;
         done     <= 1'b0;
      end else begin
         unique case (fsm)
            S_IDLE: begin
               if (En) begin
                  key_win <= cipher_key;
                  st      <= data_in ^ cipher_key[127:0];
                  rnd     <= 4'd1;
                  fsm     <= S_RUN;
               end
            end
            S_RUN: begin
               st      <= round_out;
               key_win <= {new_words, key_win[255:128]};
               if (rnd == 4'(NR)) begin
                  data_out <= round_out;
                  done     <= 1'b1;
                  fsm      <= S_DONE;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            S_DONE: begin
               if (!En) begin
                  done <= 1'b0;
                  fsm  <= S_IDLE;
               end
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

`ifdef AES256_BUSY_EN
   assign busy = (fsm == S_RUN);
`endif

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Directed bench for aes256_encrypt_core using FIPS-197 and all-zero vectors.
// Build with +define+AES256_BUSY_EN to also check the busy output.
module tb_aes256_encrypt_core;

   localparam logic [255:0] K_FIPS =
      256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] P_FIPS = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] C_FIPS = 128'h8960494b9049fceabf456751cab7a28e;
   localparam logic [127:0] C_ZERO = 128'h8720849214a248ad898940a278c095dc;

   logic         Clk;
   logic         Rst;
   logic         En;
   logic [255:0] cipher_key;
   logic [127:0] data_in;
   logic [127:0] data_out;
   logic         done;
`ifdef AES256_BUSY_EN
   logic         busy;
`endif

   int tests;
   int fails;
   int lat;
   int bcnt;

   aes256_encrypt_core dut (
      .Clk(Clk),
      .Rst(Rst),
      .En(En),
      .cipher_key(cipher_key),
      .data_in(data_in),
      .data_out(data_out),
`ifdef AES256_BUSY_EN
      .busy(busy),
`endif
      .done(done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic busy_now();
`ifdef AES256_BUSY_EN
      return busy;
`else
      return 1'b0;
`endif
   endfunction

   // Start a block and wait (bounded) for done; reports edges after the start edge.
   task automatic run(input logic [255:0] k, input logic [127:0] d,
                      input bit drop_en, input bit scramble,
                      output int n, output int bc);
      @(negedge Clk);
      cipher_key = k;
      data_in    = d;
      En         = 1'b1;
      @(posedge Clk);
      #1;
      n  = 0;
      bc = 0;
      while (!done && n < 40) begin
         if (busy_now()) bc++;
         if (drop_en) En = 1'b0;
         if (scramble) begin
            cipher_key = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
            data_in    = {$urandom, $urandom, $urandom, $urandom};
         end
         @(posedge Clk);
         #1;
         n++;
      end
      if (busy_now()) bc++;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      Rst = 1'b0;
      En = 1'b0;
      cipher_key = '0;
      data_in = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_done", 128'(done), 128'd0);
      chk("reset_dout", data_out, 128'd0);
      @(negedge Clk);
      Rst = 1'b1;

      run(K_FIPS, P_FIPS, 1'b0, 1'b0, lat, bcnt);
      chk("fips_latency", 128'(lat), 128'd14);
      chk("fips_dout", data_out, C_FIPS);
`ifdef AES256_BUSY_EN
      chk("fips_busy_cycles", 128'(bcnt), 128'd14);
`endif

      for (int i = 0; i < 12; i++) begin
         @(posedge Clk);
         #1;
         chk("hold_done", 128'(done), 128'd1);
         chk("hold_dout", data_out, C_FIPS);
`ifdef AES256_BUSY_EN
         chk("hold_busy", 128'(busy), 128'd0);
`endif
      end

      @(negedge Clk);
      En = 1'b0;
      @(posedge Clk);
      #1;
      chk("drop_en_done", 128'(done), 128'd0);
      chk("drop_en_dout", data_out, C_FIPS);

      run('0, '0, 1'b1, 1'b0, lat, bcnt);
      chk("zero_latency", 128'(lat), 128'd14);
      chk("zero_dout", data_out, C_ZERO);
`ifdef AES256_BUSY_EN
      chk("zero_busy_cycles", 128'(bcnt), 128'd14);
`endif
      @(posedge Clk);
      #1;
      chk("auto_exit_done", 128'(done), 128'd0);
      chk("auto_exit_dout", data_out, C_ZERO);

      run(K_FIPS, P_FIPS, 1'b1, 1'b1, lat, bcnt);
      chk("isolate_latency", 128'(lat), 128'd14);
      chk("isolate_dout", data_out, C_FIPS);
      @(negedge Clk);
      cipher_key = '0;
      data_in = '0;
      @(posedge Clk);
      #1;
      chk("isolate_exit", 128'(done), 128'd0);

      @(negedge Clk);
      En = 1'b1;
      @(posedge Clk);
      #1;
      En = 1'b0;
      repeat (6) @(posedge Clk);
      #2;
      Rst = 1'b0;
      #1;
      chk("abort_done", 128'(done), 128'd0);
      chk("abort_dout", data_out, 128'd0);
      @(negedge Clk);
      Rst = 1'b1;
      repeat (4) @(posedge Clk);
      #1;
      chk("idle_after_abort", 128'(done), 128'd0);
`ifdef AES256_BUSY_EN
      chk("idle_busy", 128'(busy), 128'd0);
`endif

      run(K_FIPS, P_FIPS, 1'b1, 1'b0, lat, bcnt);
      chk("post_abort_latency", 128'(lat), 128'd14);
      chk("post_abort_dout", data_out, C_FIPS);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
